// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline-boundary select blocks.
//   skid_state_t : occupancy state of the two-entry output skid buffer
//   sel_width()  : select width for an n-way mux, never below one bit
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational NUM_INPUTS:1 select with out-of-range detection.
//   in_data : concatenated sources, source k at [k*WIDTH +: WIDTH]
//   sel     : source index
//   data    : selected source, all-zero when sel is out of range
//   err     : 1 when sel >= NUM_INPUTS
module mux_n #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 2,
    parameter int SEL_W      = 1
) (
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            sel,
    output logic [WIDTH-1:0]            data,
    output logic                        err
);

    // Default to the out-of-range result; a matching index overrides it.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_skid_mux.sv
// N-way select mux feeding a registered two-entry skid buffer, used where a
// selected datapath value crosses a pipeline stage boundary.
//   clk, rst               : clock, synchronous active-high reset
//   in_data, sel, in_valid : upstream offer; in_ready back to upstream
//   flush                  : drop all held entries (bubble)
//   out_data/sel/err/valid : head entry; out_ready from downstream
//
// state | meaning
// EMPTY | no entries held
// ONE   | main (head) entry valid
// FULL  | main and skid entries valid, skid is the younger
module pipe_skid_mux
    import mips_pipe_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int NUM_INPUTS = 2,
    localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_err,
    output logic                        out_valid,
    input  logic                        out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } entry_t;

    skid_state_t      state_q;
    skid_state_t      state_d;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           new_entry;
    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic             accept;
    logic             drain;
    logic             load_main_new;
    logic             load_main_skid;
    logic             load_skid;

    mux_n #(
        .WIDTH      (WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_W      (SEL_W)
    ) u_mux (
        .in_data (in_data),
        .sel     (sel),
        .data    (mux_data),
        .err     (mux_err)
    );

    assign new_entry = '{data: mux_data, sel: sel, err: mux_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !drain)      state_d = FULL;
                    else if (drain && !accept) state_d = EMPTY;
                end
                FULL:    if (drain) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready depends only on registered state, so out_ready never reaches
    // it combinationally.
    always_comb begin
        in_ready       = (state_q != FULL);
        out_valid      = (state_q != EMPTY);
        accept         = in_valid && in_ready;
        drain          = out_valid && out_ready;
        load_main_new  = accept && ((state_q == EMPTY) || ((state_q == ONE) && drain));
        load_skid      = accept && (state_q == ONE) && !drain;
        load_main_skid = drain && (state_q == FULL);
    end

    // Flush clears the entries as well, so a bubble never exposes old data.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_new) begin
                main_q <= new_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    assign out_data = main_q.data;
    assign out_sel  = main_q.sel;
    assign out_err  = main_q.err;

endmodule

// File: tb/tb_pipe_skid_mux.sv
module tb_pipe_skid_mux;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        err;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  sel = '0;
    logic [31:0] src [4];

    logic [127:0] in_data4;
    logic [95:0]  in_data3;

    logic        in_ready4, out_valid4, out_err4;
    logic [31:0] out_data4;
    logic [1:0]  out_sel4;
    logic        in_ready3, out_valid3, out_err3;
    logic [31:0] out_data3;
    logic [1:0]  out_sel3;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   seen_edge = 0;
    bit   done = 0;
    bit   prev_rst = 0;
    ent_t q4[$];
    ent_t q3[$];

    assign in_data4 = {src[3], src[2], src[1], src[0]};
    assign in_data3 = {src[2], src[1], src[0]};

    pipe_skid_mux #(.WIDTH(32), .NUM_INPUTS(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready4), .flush(flush), .out_data(out_data4), .out_sel(out_sel4),
        .out_err(out_err4), .out_valid(out_valid4), .out_ready(out_ready)
    );

    pipe_skid_mux #(.WIDTH(32), .NUM_INPUTS(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_sel(out_sel3),
        .out_err(out_err3), .out_valid(out_valid3), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) seen_edge <= 1'b1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, got, exp);
        end
    endtask

    // Expected entry for an n-way mux given the current sources and select.
    function automatic ent_t model(input int n, input logic [1:0] s);
        ent_t e;
        e.sel = s;
        if (int'(s) < n) begin
            e.data = src[s];
            e.err  = 1'b0;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    // Reference behaviour: a FIFO of capacity two. Checks the outputs presented
    // this cycle, then applies what the coming edge will do.
    task automatic score(input int n, input logic ov, input logic ir,
                         input logic [31:0] od, input logic [1:0] os, input logic oe);
        ent_t head;
        int   sz;
        bit   acc, drn;
        string tag;
        tag = (n == 4) ? "n4" : "n3";
        sz  = (n == 4) ? q4.size() : q3.size();
        check({tag, " out_valid"}, 32'(ov), 32'(sz != 0));
        check({tag, " in_ready"},  32'(ir), 32'(sz < 2));
        if (prev_rst) begin
            check({tag, " rst out_data"}, od, 32'h0);
            check({tag, " rst out_sel"},  32'(os), 32'h0);
            check({tag, " rst out_err"},  32'(oe), 32'h0);
        end
        if (sz != 0) begin
            head = (n == 4) ? q4[0] : q3[0];
            check({tag, " out_data"}, od, head.data);
            check({tag, " out_sel"},  32'(os), 32'(head.sel));
            check({tag, " out_err"},  32'(oe), 32'(head.err));
        end
        drn = (sz != 0) && out_ready;
        acc = in_valid && (sz < 2);
        if (rst || flush) begin
            if (n == 4) q4.delete(); else q3.delete();
        end else begin
            if (drn) begin
                if (n == 4) void'(q4.pop_front()); else void'(q3.pop_front());
            end
            if (acc) begin
                if (n == 4) q4.push_back(model(4, sel)); else q3.push_back(model(3, sel));
            end
        end
    endtask

    // Inputs only change just after a rising edge, so the falling edge sees
    // exactly what the next rising edge will sample.
    always @(negedge clk) begin
        if (seen_edge && !done) begin
            score(4, out_valid4, in_ready4, out_data4, out_sel4, out_err4);
            score(3, out_valid3, in_ready3, out_data3, out_sel3, out_err3);
            prev_rst = rst;
        end
    end

    task automatic drive(input bit v, input logic [1:0] s, input bit ordy, input bit fl, input bit r);
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33; src[3] = 32'h44;

        // Reset, then a single pass with sel=2.
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 1);
        drive(1, 2, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // Streaming sweep; sel=3 is out of range for the 3-way instance.
        for (int i = 0; i < 4; i++) drive(1, 2'(i), 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // Back-pressure: fill to FULL, hold, then release.
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // Explicit out-of-range select.
        drive(1, 3, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // Flush while FULL with an offer in the same cycle.
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 2, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // Reset mid-burst.
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        drive(1, 2, 1, 0, 1);
        drive(1, 3, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) src[k] = $urandom;
            drive(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 2) != 0),
                  bit'($urandom_range(0, 24) == 0), bit'($urandom_range(0, 59) == 0));
        end
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
